// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of a single stalling memory.
// One transaction at a time: IDLE -> RD|WR -> RESP -> IDLE.
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic              if_write,
  input  logic [ADDR_W-1:0] if_address,
  input  logic [DATA_W-1:0] if_write_data,
  output logic              if_done,
  output logic [DATA_W-1:0] if_read_data,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_address,
  input  logic [DATA_W-1:0] dm_write_data,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_read_data,
  output logic              dm_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_stall,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_q, state_d;
  logic              gnt_q;         // 1 = data port owns the current transaction
  logic              last_grant_q;  // 1 = data port was served last
  logic [CNT_W-1:0]  cnt_q;
  logic              seen_busy_q;
  logic              timeout_err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic pick_dm, pick_write, grant_en, rd_done, rd_timeout;

  // Data port wins unless the fetch port is alone or the data port went last.
  assign pick_dm    = dm_req && (!if_req || !last_grant_q);
  assign pick_write = pick_dm ? dm_write : if_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_en   = 1'b0;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_en = 1'b1;
          state_d  = pick_write ? WR : RD;
        end
      end
      RD: begin
        // A read only counts as finished once the memory has shown it was busy.
        if (seen_busy_q && !mem_stall) begin
          rd_done = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rd_timeout = 1'b1;
          state_d    = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q         <= 1'b0;
      last_grant_q  <= 1'b0;
      cnt_q         <= '0;
      seen_busy_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            gnt_q       <= pick_dm;
            cnt_q       <= '0;
            seen_busy_q <= 1'b0;
          end
        end
        RD: begin
          cnt_q <= cnt_q + 1'b1;
          if (mem_stall) seen_busy_q <= 1'b1;
          if (rd_done) begin
            if (gnt_q) dm_rdata_q <= mem_read_data;
            else       if_rdata_q <= mem_read_data;
          end else if (rd_timeout) begin
            if (gnt_q) dm_rdata_q <= '0;
            else       if_rdata_q <= '0;
            timeout_err_q <= 1'b1;
          end
        end
        RESP:    last_grant_q <= gnt_q;
        default: ;
      endcase
    end
  end

  // Request fields are captured at grant so the requester may drop req afterwards.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      addr_q  <= pick_dm ? dm_address    : if_address;
      wdata_q <= pick_dm ? dm_write_data : if_write_data;
    end
  end

  assign mem_read       = (state_q == RD);
  assign mem_write      = (state_q == WR);
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

  assign if_done      = (state_q == RESP) && !gnt_q;
  assign dm_done      = (state_q == RESP) &&  gnt_q;
  assign if_stall     = if_req && !if_done;
  assign dm_stall     = dm_req && !dm_done;
  assign if_read_data = if_rdata_q;
  assign dm_read_data = dm_rdata_q;
  assign timeout_err  = timeout_err_q;

endmodule
